// File: rtl/stack_lifo_param.sv
// Purpose : parametrised LIFO stack (push / pop / peek-by-depth) used as scratch storage
//           between a command sequencer and the datapath.
// Latency : data_out/rd_valid/err update one cycle after the command edge; status reflects post-edge state.
// Backpr. : none, always ready; one command per cycle; illegal commands are dropped with an err pulse.
//
// Ports:
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-high reset (assert async, release synchronised here)
//   cmd_valid  in   1        command strobe; low = NOP
//   cmd        in   2        00 NOP, 01 PUSH, 10 POP, 11 PEEK
//   data_in    in   WIDTH    PUSH operand
//   index      in   IDX_W    PEEK depth, 0 = top of stack
//   data_out   out  WIDTH    registered POP/PEEK result, holds otherwise
//   rd_valid   out  1        one-cycle pulse, data_out updated
//   err        out  1        one-cycle pulse, illegal command rejected
//   full       out  1        count == DEPTH
//   empty      out  1        count == 0
//   count      out  IDX_W+1  number of valid entries, 0..DEPTH
//
// Build option: define STACK_LIFO_CIRCULAR_EN to make PUSH-when-full overwrite the
// oldest entry instead of being rejected.

module stack_lifo_param #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 5,
  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  input  logic [IDX_W-1:0] index,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             err,
  output logic             full,
  output logic             empty,
  output logic [IDX_W:0]   count
);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_PEEK = 2'b11;

`ifdef STACK_LIFO_CIRCULAR_EN
  localparam bit CIRCULAR = 1'b1;
`else
  localparam bit CIRCULAR = 1'b0;
`endif

  // Constants sized to the fields they are combined with.
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] PTR_MAX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W+1:0] ADR_DEPTH = (IDX_W + 2)'(DEPTH);
  localparam logic [IDX_W+1:0] ADR_DM1   = (IDX_W + 2)'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge after two stages so
  // the state flops all leave reset in the same cycle.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  assign rst_int    = rst_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] top_q, top_d;        // next free slot
  logic [IDX_W:0]   count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;

  logic             mem_we;

  // ---------------------------------------------------------------------------
  // Command decode (commands arriving while reset is still held are discarded)
  // ---------------------------------------------------------------------------
  logic cmd_acc;
  logic is_push, is_pop, is_peek;
  logic st_full, st_empty;
  logic push_ok, pop_ok, peek_ok;

  assign cmd_acc  = cmd_valid && !rst_int;
  assign is_push  = cmd_acc && (cmd == CMD_PUSH);
  assign is_pop   = cmd_acc && (cmd == CMD_POP);
  assign is_peek  = cmd_acc && (cmd == CMD_PEEK);

  assign st_full  = (count_q == CNT_FULL);
  assign st_empty = (count_q == '0);

  assign push_ok  = !st_full || CIRCULAR;
  assign pop_ok   = !st_empty;
  assign peek_ok  = ({1'b0, index} < count_q);

  // ---------------------------------------------------------------------------
  // Pointer arithmetic, all modulo DEPTH (DEPTH need not be a power of two).
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] top_inc, top_dec;
  logic [IDX_W-1:0] rd_depth;
  logic [IDX_W+1:0] rd_sum;
  logic [IDX_W-1:0] rd_addr;

  assign top_inc = (top_q == PTR_MAX) ? '0 : top_q + PTR_ONE;
  assign top_dec = (top_q == '0)      ? PTR_MAX : top_q - PTR_ONE;

  // Read slot = top - 1 - depth (mod DEPTH). Adding DEPTH-1 first keeps the sum
  // non-negative for every legal depth (depth < count <= DEPTH), so one
  // conditional subtract finishes the modulo.
  assign rd_depth = is_peek ? index : '0;
  assign rd_sum   = {2'b00, top_q} + ADR_DM1 - {2'b00, rd_depth};
  assign rd_addr  = (rd_sum >= ADR_DEPTH) ? IDX_W'(rd_sum - ADR_DEPTH) : IDX_W'(rd_sum);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    top_d      = top_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;

    if (is_push) begin
      if (push_ok) begin
        // In circular mode a push on a full stack lands on mem[top], which is
        // the oldest entry; count saturates at DEPTH.
        mem_we = 1'b1;
        top_d  = top_inc;
        if (!st_full) begin
          count_d = count_q + CNT_ONE;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (is_pop) begin
      if (pop_ok) begin
        data_out_d = mem_q[rd_addr];
        top_d      = top_dec;
        count_d    = count_q - CNT_ONE;
        rd_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (is_peek) begin
      if (peek_ok) begin
        data_out_d = mem_q[rd_addr];
        rd_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q      <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (rst_int) begin
      top_q      <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      top_q      <= top_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately not reset: count gates every read, so stale
  // contents can never reach data_out.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[top_q] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign count    = count_q;
  assign full     = st_full;
  assign empty    = st_empty;

endmodule
